// File: rtl/mem_access_unit.sv
// Load/store unit: byte/half/word accesses to a 32-bit word RAM, read-modify-write for sub-word stores.
// Optional alignment checking is compiled in with `define MEM_ACCESS_ALIGN_CHECK_EN.
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t            state_reg, state_next;
  logic              write_reg, signed_reg;
  logic [1:0]        size_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg, rword_reg, rdata_reg;
  logic              accept, req_word, req_misalign;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;
  logic [31:0]       load_val, merge_word;

  assign accept   = req_valid && (state_reg == IDLE);
  // Size 11 is reserved and behaves exactly like a word access.
  assign req_word = req_size[1];

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  logic err_reg;
  assign req_misalign = req_word ? (req_addr[1:0] != 2'b00) : (req_size[0] && req_addr[0]);
  assign rsp_err      = rsp_valid && err_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       err_reg <= 1'b0;
    else if (accept) err_reg <= req_misalign;
  end
`else
  assign req_misalign = 1'b0;
  assign rsp_err      = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (req_misalign)             state_next = RESP;
          else if (req_write && req_word) state_next = WRITE;
          else                          state_next = READ;
        end
      end
      READ:    state_next = write_reg ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      write_reg  <= 1'b0;
      signed_reg <= 1'b0;
      size_reg   <= 2'b00;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rword_reg  <= '0;
      rdata_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        write_reg  <= req_write;
        signed_reg <= req_signed;
        size_reg   <= req_size;
        addr_reg   <= req_addr;
        wdata_reg  <= req_wdata;
      end
      if (state_reg == READ) begin
        rword_reg <= ram_rdata;
        if (!write_reg) rdata_reg <= load_val;
      end
    end
  end

  // Load lane extraction straight from the RAM word so the result lands on the READ->RESP edge.
  always_comb begin
    case (addr_reg[1:0])
      2'd0:    load_byte = ram_rdata[7:0];
      2'd1:    load_byte = ram_rdata[15:8];
      2'd2:    load_byte = ram_rdata[23:16];
      default: load_byte = ram_rdata[31:24];
    endcase
    load_half = addr_reg[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (size_reg)
      2'b00:   load_val = {{24{signed_reg && load_byte[7]}}, load_byte};
      2'b01:   load_val = {{16{signed_reg && load_half[15]}}, load_half};
      default: load_val = ram_rdata;
    endcase
  end

  // Per-lane merge: a word store hits every lane, so the stale read word never leaks through.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic       lane_hit;
    logic [7:0] lane_data;
    assign lane_hit  = size_reg[1] ? 1'b1 :
                       size_reg[0] ? (addr_reg[1] == 1'(gi / 2)) : (addr_reg[1:0] == 2'(gi));
    assign lane_data = size_reg[1] ? wdata_reg[8*gi +: 8] :
                       size_reg[0] ? wdata_reg[8*(gi % 2) +: 8] : wdata_reg[7:0];
    assign merge_word[8*gi +: 8] = lane_hit ? lane_data : rword_reg[8*gi +: 8];
  end

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign rsp_rdata = rdata_reg;
  assign ram_we    = (state_reg == WRITE);
  assign ram_addr  = (state_reg == READ || state_reg == WRITE) ? {addr_reg[ADDR_W-1:2], 2'b00} : '0;
  assign ram_wdata = (state_reg == WRITE) ? merge_word : 32'h0;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the byte-address width of the request and RAM address ports.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-004 SHALL have port req_valid  input  1  access request present.
REQ-005 SHALL have port req_ready  output  1  unit idle and able to accept a request.
REQ-006 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 half, 10 word; 11 reserved and treated as word.
REQ-008 SHALL have port req_signed  input  1  sign-extend a byte or half load.
REQ-009 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-justified.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata  output  32  load result, held until the next rsp_valid.
REQ-013 SHALL have port rsp_err  output  1  misaligned access flag, qualified by rsp_valid.
REQ-014 SHALL have port ram_we  output  1  RAM word write enable.
REQ-015 SHALL have port ram_addr  output  ADDR_W  word-aligned RAM address, with bits [1:0] always 00.
REQ-016 SHALL have port ram_wdata  output  32  RAM write word.
REQ-017 SHALL have port ram_rdata  input  32  RAM combinational read word, little-endian.

Function
REQ-018 SHALL implement the FSM states IDLE, READ, WRITE and RESP, with req_ready=1 only in IDLE.
REQ-019 SHALL accept a request on a clock edge where req_valid and req_ready are both 1, latching write, size, signed, addr and wdata, and SHALL ignore req_* in every other state.
REQ-020 SHALL move from IDLE on accept to READ for a load or a byte/half store, to WRITE for a word store, and to RESP for a misaligned request.
REQ-021 SHALL drive ram_addr from the latched address with bits [1:0] forced to 00 in READ and WRITE.
REQ-022 SHALL, in READ with ram_we=0, register ram_rdata; for a load it SHALL go to RESP, and for a store it SHALL go to WRITE.
REQ-023 SHALL select the byte lane as addr[1:0] and the half lane as addr[1]; a load SHALL extract that lane into rsp_rdata, zero- or sign-extended per req_signed.
REQ-024 SHALL, in WRITE, assert ram_we for exactly one cycle with ram_wdata = the registered read word with only the target lane(s) replaced by req_wdata[7:0] or [15:0]; a word store SHALL write req_wdata directly. The next state SHALL be RESP.
REQ-025 SHALL, in RESP, assert rsp_valid for one cycle and return to IDLE.
REQ-026 Latency from the accept edge to rsp_valid SHALL be 2 cycles for a load, 2 cycles for a word store and 3 cycles for a byte/half store.
REQ-027 SHALL leave rsp_rdata unchanged on a store and on an errored access.
REQ-028 SHALL assert ram_we only in WRITE.
REQ-029 SHALL allow back-to-back requests, with the next accept taking place in the cycle after RESP.

Reset
REQ-030 SHALL asynchronously force the FSM to IDLE and set req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, ram_we=0, ram_addr=0 and ram_wdata=0.
REQ-031 A reset asserted mid-access SHALL abort the access with no response and no RAM write after the reset edge.

Configuration
REQ-032 SHALL compile alignment checking in when MEM_ACCESS_ALIGN_CHECK_EN is defined: a half access with addr[0]=1 or a word access with addr[1:0]!=00 SHALL go directly to RESP with rsp_err=1 and no RAM write.
REQ-033 SHALL, when MEM_ACCESS_ALIGN_CHECK_EN is undefined, tie rsp_err to 0 and ignore the misaligned low address bits: half accesses ignore addr[0] and word accesses ignore addr[1:0].

Verification
REQ-034 SHALL cover a word store of 0xDEADBEEF to address 0x10 -> a single ram_we pulse with ram_addr 0x10 and data 0xDEADBEEF, then rsp_valid 2 cycles after accept.
REQ-035 SHALL cover a RAM word 0x11223344 at 0x20 followed by a byte store of 0xAA to 0x22 -> a read, then a write of 0x11AA3344 and rsp_valid 3 cycles after accept.
REQ-036 SHALL cover a RAM word 0x80FF7F01 at 0x30 with a signed byte load at 0x32 -> 0xFFFFFFFF, and an unsigned half load at 0x30 -> 0x00007F01.
REQ-037 SHALL cover a half load at 0x31 with MEM_ACCESS_ALIGN_CHECK_EN defined -> rsp_err=1 one cycle after accept with no ram_we; with the macro undefined -> data from 0x30 and rsp_err=0.
REQ-038 SHALL cover reset asserted in READ of a byte store -> ram_we never asserts and req_ready=1 immediately.
REQ-039 SHALL cover req_valid held high for three consecutive loads -> three rsp_valid pulses 3 cycles apart, with req_ready low between accepts.
